// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver for common-anode displays.
// Double-buffered display value, guard blanking per digit slot, leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_blank,
    input  logic                      enable,
    output logic [6:0]                segs,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            4'hF:    g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_restart;
    logic [VAL_W-1:0]      r_shadow_val;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [VAL_W-1:0]      r_active_val;
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic                  r_pending;
    logic [6:0]            r_segs;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [3:0]            w_nib;
    logic                  w_upper_zero;
    logic                  w_lz;
    logic [6:0]            w_segs;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an;

    // After a disabled stretch the slot count restarts at zero for the current digit.
    always_comb begin
        w_cnt       = r_restart ? {CNT_W{1'b0}} : r_cnt;
        w_slot_end  = enable && (w_cnt == CNT_W'(REFRESH_DIV - 1));
        w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    end

    // Leading-zero detection: this digit and every more significant digit are zero.
    always_comb begin
        w_nib        = r_active_val[r_idx*4 +: 4];
        w_upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(r_idx)) && (r_active_val[j*4 +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end else begin
                w_upper_zero = w_upper_zero;
            end
        end
        w_lz = lz_blank && (r_idx != {IDX_W{1'b0}}) && w_upper_zero;
    end

    // Next output values: dark during guard interval or when disabled.
    always_comb begin
        w_an   = {NUM_DIGITS{1'b1}};
        w_segs = 7'b1111111;
        w_dp   = 1'b1;
        if (enable && (w_cnt >= CNT_W'(GUARD))) begin
            w_an[r_idx] = 1'b0;
            w_segs      = w_lz ? 7'b1111111 : glyph(w_nib);
            w_dp        = ~r_active_dp[r_idx];
        end else begin
            w_an   = {NUM_DIGITS{1'b1}};
            w_segs = 7'b1111111;
            w_dp   = 1'b1;
        end
    end

    // Slot counter and digit index; frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_restart <= 1'b0;
        end else if (enable) begin
            r_restart <= 1'b0;
            if (w_slot_end) begin
                r_cnt <= {CNT_W{1'b0}};
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= w_cnt + CNT_W'(1);
            end
        end else begin
            r_restart <= 1'b1;
        end
    end

    // Shadow/active double buffer; active only changes on a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= {VAL_W{1'b0}};
            r_shadow_dp  <= {NUM_DIGITS{1'b0}};
            r_active_val <= {VAL_W{1'b0}};
            r_active_dp  <= {NUM_DIGITS{1'b0}};
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_frame_end) begin
                if (load) begin
                    r_active_val <= value;
                    r_active_dp  <= dp_in;
                end else if (r_pending) begin
                    r_active_val <= r_shadow_val;
                    r_active_dp  <= r_shadow_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs       <= 7'b1111111;
            r_dp         <= 1'b1;
            r_an         <= {NUM_DIGITS{1'b1}};
            r_frame_done <= 1'b0;
        end else begin
            r_segs       <= w_segs;
            r_dp         <= w_dp;
            r_an         <= w_an;
            r_frame_done <= w_frame_end;
        end
    end

    assign segs       = r_segs;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-cycle comparison against a
// frame-position reference model, with directed and randomized scenarios.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int G  = 2;
    localparam int FRAME = N * RD;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [15:0]  value;
    logic [3:0]   dp_in;
    logic         lz_blank;
    logic         enable;
    logic [6:0]   segs;
    logic         dp;
    logic [3:0]   an;
    logic         frame_done;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .lz_blank(lz_blank), .enable(enable), .segs(segs), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] GLYPH [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame, plus buffers.
    int          m_pos;
    bit          m_restart;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_act_dp, m_sh_dp;
    logic [6:0]  e_segs;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    task automatic model_reset();
        m_pos = 0; m_restart = 1'b0;
        m_act = 16'h0; m_sh = 16'h0; m_act_dp = 4'h0; m_sh_dp = 4'h0;
    endtask

    // Predict the outputs of the coming edge, advance the model, then clock.
    task automatic step();
        int eff, id, c;
        logic [3:0] nib;
        eff = m_restart ? (m_pos / RD) * RD : m_pos;
        id  = eff / RD;
        c   = eff % RD;
        e_an = 4'hF; e_segs = 7'h7F; e_dp = 1'b1;
        e_fd = enable && (eff == FRAME - 1);
        if (enable && c >= G) begin
            e_an[id] = 1'b0;
            nib = m_act[id*4 +: 4];
            if (lz_blank && id > 0 && (m_act >> (id*4)) == 16'h0) e_segs = 7'h7F;
            else e_segs = GLYPH[nib];
            e_dp = ~m_act_dp[id];
        end
        if (enable) begin
            if (eff == FRAME - 1) begin
                m_act    = load ? value : m_sh;
                m_act_dp = load ? dp_in : m_sh_dp;
            end
            m_pos = (eff + 1) % FRAME;
            m_restart = 1'b0;
        end else begin
            m_restart = 1'b1;
        end
        if (load) begin
            m_sh = value; m_sh_dp = dp_in;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        lz_blank = 1'b0; enable = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({segs, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset got=%b exp=%b", {segs, dp, an, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        int last_fd, gap_bad;
        value = 16'h1234; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
            errors++; $display("FAIL scan_load got=%b exp=%b", {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
        end
        last_fd = -1; gap_bad = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL scan cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0 && k - last_fd != 32) gap_bad++;
                last_fd = k;
            end
        end
        checks++;
        if (gap_bad != 0 || last_fd < 0) begin
            errors++; $display("FAIL frame_period bad_gaps=%0d last=%0d required gap=32", gap_bad, last_fd);
        end
    endtask

    task automatic test_midframe_load();
        int guard_cnt;
        guard_cnt = 0;
        while (!(m_pos / RD == 1 && m_pos % RD == 3) && guard_cnt < 100) begin
            step(); guard_cnt++;
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL mid_wait got=%b exp=%b", {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
        end
        value = 16'hABCD; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 2 * FRAME + 5; k++) begin
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL mid_load cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [2];
        vals[0] = 16'h0050; vals[1] = 16'h0000;
        lz_blank = 1'b1;
        for (int v = 0; v < 2; v++) begin
            value = vals[v]; load = 1'b1;
            step();
            load = 1'b0;
            for (int k = 0; k < 2 * FRAME; k++) begin
                step();
                checks++;
                if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                    errors++; $display("FAIL lz v=%h cyc=%0d got=%b exp=%b", vals[v], k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_dp();
        value = 16'h8888; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL dp cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
        end
        dp_in = 4'h0;
    endtask

    task automatic test_enable();
        int guard_cnt;
        guard_cnt = 0;
        while (!(m_pos / RD == 2 && m_pos % RD == 4) && guard_cnt < 100) begin
            step(); guard_cnt++;
        end
        enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
                errors++; $display("FAIL disabled cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (an !== ((k < 2) ? 4'hF : 4'b1011)) begin
                errors++; $display("FAIL reenable_an cyc=%0d got=%b exp=%b", k, an, (k < 2) ? 4'hF : 4'b1011);
            end
        end
        for (int k = 0; k < FRAME; k++) begin
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL reenable cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            load     = ($urandom_range(0, 7) == 0);
            value    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            dp_in    = 4'($urandom);
            enable   = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL random cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
        end
        load = 1'b0; enable = 1'b1; lz_blank = 1'b0;
    endtask

    task automatic test_async_reset();
        int guard_cnt;
        value = 16'h5A5A; load = 1'b1;
        step();
        load = 1'b0;
        guard_cnt = 0;
        while (an === 4'hF && guard_cnt < 100) begin
            step(); guard_cnt++;
        end
        checks++;
        if (an === 4'hF) begin
            errors++; $display("FAIL show_wait timeout an=%b", an);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({segs, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++; $display("FAIL async_reset got=%b exp=%b", {segs, dp, an, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < FRAME + 4; k++) begin
            step();
            checks++;
            if ({segs, dp, an, frame_done} !== {e_segs, e_dp, e_an, e_fd}) begin
                errors++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", k, {segs, dp, an, frame_done}, {e_segs, e_dp, e_an, e_fd});
            end
            if (an === 4'b1110) begin
                checks++;
                if (segs !== 7'b0000001) begin
                    errors++; $display("FAIL post_reset_zero got=%b exp=%b", segs, 7'b0000001);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_lz_blank();
        test_dp();
        test_enable();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
